conv_channel_scheduler: RTL and testbench

Sequencer for the 5x5 column-parallel convolution engine. It runs one full-image pass per output channel, pulsing the engine's start and selecting that channel's kernel bank. It collects the engine's output-column strobes and turns each one into an addressed write request to the feature-map buffer. It sits between the layer-level control FSM and one convolution engine instance, so a multi-kernel layer runs as a single start/done transaction.

---
 rtl/conv_channel_scheduler.sv | 268 ++++++++++++++++++++++++++
 tb/tb_conv_channel_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_scheduler.sv
// conv_channel_scheduler
//
// Runs one full-image pass of a 5x5 column-parallel convolution engine for
// each output channel of a layer. For every channel it pulses eng_start with
// that channel's kernel bank selected. It then turns each engine
// output-column strobe into an addressed write request to the feature-map
// buffer. The layer-level controller sees a single start/done transaction.
//
// Optional feature: define SCHED_WATCHDOG_EN to add a per-channel RUN
// timeout. When the timeout expires, err_timeout is set and the pass ends as
// if aborted. Without the macro, err_timeout is tied low.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          pulse, begins a layer pass (only seen in IDLE)
//   abort          synchronous kill of the pass from any non-IDLE state
//   busy           high in every state except IDLE
//   done           one-cycle pulse at the end of a successful pass
//   eng_start      one-cycle engine start pulse
//   eng_channel    kernel bank select, stable through a channel
//   eng_done       engine pass-complete pulse
//   eng_col_valid  engine output-column strobe (cannot be stalled)
//   eng_col_num    column index qualifying eng_col_valid
//   wr_req         write request, high while the column FIFO holds data
//   wr_ready       buffer accept; a transfer is wr_req && wr_ready
//   wr_addr        BASE_ADDR + ch*OUT_COLS + col of the FIFO head
//   err_overflow   sticky, a column was lost to a full FIFO
//   err_col        sticky, bad column index or wrong column count
//   err_timeout    sticky watchdog flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_LAUNCH | eng_start pulse cycle for the current channel
// S_RUN    | engine running, columns queued into the FIFO
// S_DRAIN  | engine finished, waiting for the FIFO to empty
// S_NEXT   | advance to the next channel or finish the layer
// S_FINISH | done pulse cycle
module conv_channel_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int IMAGE_SIZE   = 28,
  parameter int KERNEL_SIZE  = 5,
  parameter int ADDR_WIDTH   = 12,
  parameter int BASE_ADDR    = 0,
  parameter int WDOG_CYCLES  = 4096,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int COL_W = $clog2(IMAGE_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  eng_start,
  output logic [CH_W-1:0]       eng_channel,
  input  logic                  eng_done,
  input  logic                  eng_col_valid,
  input  logic [COL_W-1:0]      eng_col_num,
  output logic                  wr_req,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  err_overflow,
  output logic                  err_col,
  output logic                  err_timeout
);

  localparam int OUT_COLS = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int CNT_W    = $clog2(OUT_COLS + 1) + 1;
  localparam int LAST_CH  = NUM_CHANNELS - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] col_cnt;

  // Two-entry column FIFO holding {channel, column} per queued write.
  logic [CH_W-1:0]  fifo_ch  [2];
  logic [COL_W-1:0] fifo_col [2];
  logic             fifo_rd_ptr;
  logic             fifo_wr_ptr;
  logic [1:0]       fifo_cnt;

  logic fifo_full;
  logic fifo_push;
  logic fifo_pop;
  logic col_in_range;
  logic col_push_req;
  logic col_drop;
  logic col_bad;
  logic kill;
  logic wdog_expire;

  logic [ADDR_WIDTH-1:0] head_ch_off;

  assign col_in_range = (eng_col_num < COL_W'(OUT_COLS));
  assign col_push_req = (state == S_RUN) && eng_col_valid && col_in_range;
  assign col_bad      = (state == S_RUN) && eng_col_valid && !col_in_range;

  assign fifo_full = (fifo_cnt == 2'd2);
  assign wr_req    = (fifo_cnt != 2'd0);
  assign fifo_pop  = wr_req && wr_ready;

  // abort and watchdog expiry share one exit path: back to IDLE, FIFO flushed.
  assign kill = (state != S_IDLE) && (abort || wdog_expire);

  // A full FIFO still takes a column when the head leaves in the same cycle.
  assign fifo_push = col_push_req && !kill && (!fifo_full || fifo_pop);
  assign col_drop  = col_push_req && fifo_full && !fifo_pop;

  // Both operands are ADDR_WIDTH wide, so the sum wraps modulo 2^ADDR_WIDTH.
  assign head_ch_off = ADDR_WIDTH'(OUT_COLS) * ADDR_WIDTH'(fifo_ch[fifo_rd_ptr]);
  assign wr_addr     = ADDR_WIDTH'(BASE_ADDR) + head_ch_off
                     + ADDR_WIDTH'(fifo_col[fifo_rd_ptr]);

  assign eng_channel = ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_ch[i]  <= '0;
        fifo_col[i] <= '0;
      end
    end else if (kill) begin
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_ch[fifo_wr_ptr]  <= ch;
        fifo_col[fifo_wr_ptr] <= eng_col_num;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ch           <= '0;
      col_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      eng_start    <= 1'b0;
      err_overflow <= 1'b0;
      err_col      <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      done      <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state        <= S_LAUNCH;
              busy         <= 1'b1;
              eng_start    <= 1'b1;
              ch           <= '0;
              col_cnt      <= '0;
              err_overflow <= 1'b0;
              err_col      <= 1'b0;
            end
          end
          S_LAUNCH: begin
            state <= S_RUN;
          end
          S_RUN: begin
            // Counts every in-range column the engine produced, including
            // one lost to overflow, so err_col reflects the engine alone.
            if (col_push_req && (col_cnt != '1)) begin
              col_cnt <= col_cnt + CNT_W'(1);
            end
            if (eng_done) begin
              state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (fifo_cnt == 2'd0) begin
              state <= S_NEXT;
              if (col_cnt != CNT_W'(OUT_COLS)) begin
                err_col <= 1'b1;
              end
            end
          end
          S_NEXT: begin
            if (ch == CH_W'(LAST_CH)) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state     <= S_LAUNCH;
              ch        <= ch + CH_W'(1);
              col_cnt   <= '0;
              eng_start <= 1'b1;
            end
          end
          S_FINISH: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
      if (col_drop) begin
        err_overflow <= 1'b1;
      end
      if (col_bad) begin
        err_col <= 1'b1;
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt;

  // Down-counter loaded in LAUNCH. Reaching zero in RUN marks the last
  // allowed RUN cycle. An eng_done in that same cycle still wins.
  assign wdog_expire = (state == S_RUN) && !eng_done && (wdog_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_LAUNCH) begin
        wdog_cnt <= WD_W'(WDOG_CYCLES - 1);
      end else if ((state == S_RUN) && (wdog_cnt != '0)) begin
        wdog_cnt <= wdog_cnt - WD_W'(1);
      end
      if ((state == S_IDLE) && start) begin
        err_timeout <= 1'b0;
      end else if (wdog_expire) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_conv_channel_scheduler.sv
// Bench for conv_channel_scheduler. An engine model emits columns, and a
// reference list of expected write addresses is built from
// BASE + ch*OUT_COLS + col. Captured writes are compared against that list.
module tb_conv_channel_scheduler;
  localparam int NCH      = 4;
  localparam int OUT_COLS = 24;
`ifdef SCHED_WATCHDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        eng_start;
  logic [1:0]  eng_channel;
  logic        eng_done;
  logic        eng_col_valid;
  logic [5:0]  eng_col_num;
  logic        wr_req;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic        err_overflow;
  logic        err_col;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_base;
  int got_rd   = 0;
  int exp_q[$];
  int got_q[$];
  int cols_all[$];

  always #5 clk = ~clk;

  conv_channel_scheduler #(
    .NUM_CHANNELS(NCH),
    .IMAGE_SIZE  (28),
    .KERNEL_SIZE (5),
    .ADDR_WIDTH  (12),
    .BASE_ADDR   (0),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .eng_start    (eng_start),
    .eng_channel  (eng_channel),
    .eng_done     (eng_done),
    .eng_col_valid(eng_col_valid),
    .eng_col_num  (eng_col_num),
    .wr_req       (wr_req),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .err_overflow (err_overflow),
    .err_col      (err_col),
    .err_timeout  (err_timeout)
  );

  always @(negedge clk) begin
    if (rst_n && wr_req && wr_ready) got_q.push_back(int'(wr_addr));
    if (rst_n && done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    n = got_q.size() - got_rd;
    chk({tag, "_write_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk({tag, "_write_addr"}, got_q[got_rd + i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic start_pass();
    done_base = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("start_eng_start", eng_start, 1);
    chk("start_busy", busy, 1);
    chk("start_clr_err_col", err_col, 0);
    chk("start_clr_err_ovf", err_overflow, 0);
  endtask

  // Entered at the negedge of a LAUNCH cycle. The first `stall` columns
  // arrive back to back with wr_ready low, and only two of them fit.
  task automatic run_channel(input int ch, input int cols[$], input int gap_max,
                             input int stall, input bit last, input bit inject);
    chk("eng_channel", eng_channel, ch);
    if (inject) begin
      start    = 1'b1;
      eng_done = 1'b1;
    end
    tick();
    start    = 1'b0;
    eng_done = 1'b0;
    for (int i = 0; i < cols.size(); i++) begin
      if (i == 0 && stall > 0) wr_ready = 1'b0;
      if (cols[i] < OUT_COLS && (i >= stall || i < 2))
        exp_q.push_back(ch * OUT_COLS + cols[i]);
      eng_col_valid = 1'b1;
      eng_col_num   = 6'(cols[i]);
      tick();
      eng_col_valid = 1'b0;
      if (i == stall - 1) wr_ready = 1'b1;
      if (i >= stall) repeat ($urandom_range(gap_max, 0)) tick();
    end
    repeat (3) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int k = 1; k <= (last ? 4 : 3); k++) begin
      @(negedge clk);
      chk("done_timing", done, (last && k == 3));
      chk("busy_timing", busy, (!last || k < 4));
      if (!last) chk("launch_timing", eng_start, (k == 3));
    end
  endtask

  task automatic full_pass(input int gap_max, input bit shuffle, input int stall_ch,
                           input int bad_ch, input int inject_ch);
    int cols[$];
    start_pass();
    for (int ch = 0; ch < NCH; ch++) begin
      cols.delete();
      if (ch == bad_ch) begin
        cols.push_back(OUT_COLS);
        for (int c = 0; c < OUT_COLS - 1; c++) cols.push_back(c);
      end else begin
        for (int c = 0; c < OUT_COLS; c++) cols.push_back(c);
      end
      if (shuffle) begin
        for (int i = cols.size() - 1; i > 0; i--) begin
          int j;
          int t;
          j       = $urandom_range(i, 0);
          t       = cols[i];
          cols[i] = cols[j];
          cols[j] = t;
        end
      end
      run_channel(ch, cols, gap_max, (ch == stall_ch) ? 3 : 0, ch == NCH - 1, ch == inject_ch);
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    eng_done      = 1'b0;
    eng_col_valid = 1'b0;
    eng_col_num   = '0;
    wr_ready      = 1'b1;
    for (int c = 0; c < OUT_COLS; c++) cols_all.push_back(c);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_channel", eng_channel, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_err_col", err_col, 0);
    chk("rst_err_timeout", err_timeout, 0);

    // Nominal layer: 96 writes at 0..95 in order.
    full_pass(0, 1'b0, -1, -1, -1);
    compare_writes("nominal");
    chk("nominal_done_count", done_cnt - done_base, 1);
    chk("nominal_err_overflow", err_overflow, 0);
    chk("nominal_err_col", err_col, 0);
    chk("nominal_err_timeout", err_timeout, 0);

    // Random column order and gaps.
    for (int r = 0; r < 2; r++) begin
      full_pass(3, 1'b1, -1, -1, -1);
      compare_writes("random");
      chk("random_done_count", done_cnt - done_base, 1);
      chk("random_err_overflow", err_overflow, 0);
      chk("random_err_col", err_col, 0);
    end

    // Buffer stalls for three back-to-back columns in channel 0.
    full_pass(0, 1'b0, 0, -1, -1);
    compare_writes("overflow");
    chk("overflow_done_count", done_cnt - done_base, 1);
    chk("overflow_err_overflow", err_overflow, 1);

    // Out-of-range column, then only 23 good columns, in channel 1.
    full_pass(1, 1'b0, -1, 1, -1);
    compare_writes("badcol");
    chk("badcol_done_count", done_cnt - done_base, 1);
    chk("badcol_err_col", err_col, 1);
    chk("badcol_err_overflow", err_overflow, 0);

    // start and eng_done during LAUNCH of channel 1 are ignored.
    full_pass(0, 1'b0, -1, -1, 1);
    compare_writes("inject");
    chk("inject_done_count", done_cnt - done_base, 1);
    chk("inject_err_col", err_col, 0);

    // Abort in RUN of channel 2 with one column queued.
    start_pass();
    run_channel(0, cols_all, 0, 0, 1'b0, 1'b0);
    run_channel(1, cols_all, 0, 0, 1'b0, 1'b0);
    chk("abort_channel", eng_channel, 2);
    tick();
    wr_ready      = 1'b0;
    eng_col_valid = 1'b1;
    eng_col_num   = 6'd5;
    tick();
    eng_col_valid = 1'b0;
    @(negedge clk);
    chk("abort_queued_req", wr_req, 1);
    chk("abort_queued_addr", wr_addr, 2 * OUT_COLS + 5);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_wr_req", wr_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_eng_start", eng_start, 0);
    wr_ready = 1'b1;
    repeat (5) tick();
    chk("abort_idle_wr_req", wr_req, 0);
    chk("abort_done_count", done_cnt - done_base, 0);
    compare_writes("abort");

    // Restart after abort begins again at channel 0.
    full_pass(0, 1'b0, -1, -1, -1);
    compare_writes("restart");
    chk("restart_done_count", done_cnt - done_base, 1);

`ifdef SCHED_WATCHDOG_EN
    // Engine never finishes: watchdog ends the pass after WDOG RUN cycles.
    start_pass();
    repeat (WDOG) @(negedge clk);
    chk("wdog_busy_last_run", busy, 1);
    chk("wdog_flag_before", err_timeout, 0);
    @(negedge clk);
    chk("wdog_busy_after", busy, 0);
    chk("wdog_flag_after", err_timeout, 1);
    chk("wdog_wr_req", wr_req, 0);
    repeat (3) @(negedge clk);
    chk("wdog_done_count", done_cnt - done_base, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
